unflattening_layer: RTL and testbench

UNFLATTENING_LAYER -- requirements
Module: unflattening_layer

---
 rtl/unflattening_layer_if.sv | 36 +++
 rtl/unflattening_layer.sv | 146 ++++++++++++++
 tb/tb_unflattening_layer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/unflattening_layer_if.sv
// Handshake bundle for unflattening_layer: image-vector input side and
// multi-lane pixel output side (valid/ready on both, out_last frame marker).
interface unflattening_layer_if #(
  parameter int BitSize     = 4,
  parameter int ImageSize   = 4,
  parameter int NumOfImages = 4,
  parameter int NumOfInputs = 2
);
  logic                             in_valid;
  logic                             in_ready;
  logic [ImageSize*BitSize-1:0]     in_data;
  logic                             out_ready;
  logic [NumOfImages-1:0]           out_valid;
  logic [NumOfInputs*BitSize-1:0]   out_data;
  logic                             out_last;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  out_ready,
    output out_valid,
    output out_data,
    output out_last
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output out_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/unflattening_layer.sv
// Buffers NumOfImages image vectors, then streams them pixel-by-pixel on
// NumOfInputs lanes. Ports: clk, res (async high), bus (slave modport).
module unflattening_layer #(
  parameter int BitSize        = 4,
  parameter int ImageSize      = 4,
  parameter int NumOfImages    = 4,
  parameter int NumOfInputs    = 2,
  parameter int CyclesPerPixel = 2
) (
  input logic                 clk,
  input logic                 res,
  unflattening_layer_if.slave bus
);

  if (NumOfImages != NumOfInputs * CyclesPerPixel) begin : g_bad_cfg
    $error("NumOfImages must equal NumOfInputs*CyclesPerPixel");
  end

  localparam int VW = ImageSize * BitSize;
  localparam int OW = NumOfInputs * BitSize;
  localparam int KW = NumOfImages > 1 ? $clog2(NumOfImages) : 1;
  localparam int PW = ImageSize > 1 ? $clog2(ImageSize) : 1;
  localparam int CW = CyclesPerPixel > 1 ? $clog2(CyclesPerPixel) : 1;

  localparam logic [KW-1:0] K_LAST = KW'(NumOfImages - 1);
  localparam logic [PW-1:0] P_LAST = PW'(ImageSize - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CyclesPerPixel - 1);

  typedef enum logic {LOAD, STREAM} state_t;

  state_t                 state;
  logic [KW-1:0]          img_cnt;
  logic [PW-1:0]          pix;
  logic [CW-1:0]          sub;
  logic [VW-1:0]          img_buf  [NumOfImages];
  logic [VW-1:0]          img_view [NumOfImages];
  logic [NumOfImages-1:0] valid_q;
  logic [OW-1:0]          data_q;
  logic                   last_q;

  logic                   accept;
  logic                   beat_done;
  logic [PW-1:0]          nxt_pix;
  logic [CW-1:0]          nxt_sub;
  logic [NumOfImages-1:0] nxt_valid;
  logic [OW-1:0]          nxt_data;
  logic                   nxt_last;

  assign bus.in_ready  = (state == LOAD);
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_last  = last_q;

  assign accept    = (state == LOAD) && bus.in_valid;
  assign beat_done = (state == STREAM) && bus.out_ready;

  // The last image is still on in_data when the first beat is built,
  // so bypass it around the buffer.
  always_comb begin
    for (int k = 0; k < NumOfImages; k++) begin
      img_view[k] = img_buf[k];
      if (accept && img_cnt == KW'(k))
        img_view[k] = bus.in_data;
    end
  end

  // Beat to present after the next edge: first beat when leaving LOAD,
  // otherwise the successor of the current (p,c).
  always_comb begin
    nxt_pix = P_LAST;
    nxt_sub = '0;
    if (state == STREAM) begin
      if (sub == C_LAST) begin
        nxt_sub = '0;
        nxt_pix = pix - 1'b1;
      end else begin
        nxt_sub = sub + 1'b1;
        nxt_pix = pix;
      end
    end
    nxt_valid = '0;
    nxt_data  = '0;
    for (int l = 0; l < NumOfInputs; l++) begin
      nxt_valid[int'(nxt_sub) * NumOfInputs + l] = 1'b1;
      nxt_data[l*BitSize +: BitSize] =
        img_view[int'(nxt_sub) * NumOfInputs + l]
                [int'(nxt_pix) * BitSize +: BitSize];
    end
    nxt_last = (nxt_pix == '0) && (nxt_sub == C_LAST);
  end

  always_ff @(posedge clk) begin
    if (accept)
      img_buf[img_cnt] <= bus.in_data;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state   <= LOAD;
      img_cnt <= '0;
      pix     <= '0;
      sub     <= '0;
      valid_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      unique case (state)
        LOAD: begin
          if (accept) begin
            if (img_cnt == K_LAST) begin
              img_cnt <= '0;
              state   <= STREAM;
              pix     <= nxt_pix;
              sub     <= nxt_sub;
              valid_q <= nxt_valid;
              data_q  <= nxt_data;
              last_q  <= nxt_last;
            end else begin
              img_cnt <= img_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          if (beat_done) begin
            if (last_q) begin
              state   <= LOAD;
              pix     <= '0;
              sub     <= '0;
              valid_q <= '0;
              data_q  <= '0;
              last_q  <= 1'b0;
            end else begin
              pix     <= nxt_pix;
              sub     <= nxt_sub;
              valid_q <= nxt_valid;
              data_q  <= nxt_data;
              last_q  <= nxt_last;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_unflattening_layer.sv
// Directed self-checking bench for unflattening_layer at default parameters.
// Observed vector per cycle: {out_valid, out_data, out_last, in_ready}.
module tb_unflattening_layer;

  logic clk = 1'b0;
  logic res;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  unflattening_layer_if #(
    .BitSize(4), .ImageSize(4), .NumOfImages(4), .NumOfInputs(2)
  ) bus ();

  unflattening_layer #(
    .BitSize(4), .ImageSize(4), .NumOfImages(4),
    .NumOfInputs(2), .CyclesPerPixel(2)
  ) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  wire [13:0] obs = {bus.out_valid, bus.out_data, bus.out_last, bus.in_ready};

  localparam logic [13:0] IDLE = {4'h0, 8'h00, 1'b0, 1'b1};

  logic [7:0] basic_d [2] = '{8'h21, 8'h43};
  logic [7:0] ord_d   [8] = '{8'h0A, 8'h00, 8'h0B, 8'h00,
                              8'h0C, 8'h00, 8'h0D, 8'h00};
  logic [7:0] f2_d    [8] = '{8'h51, 8'hD9, 8'h62, 8'hEA,
                              8'h73, 8'hFB, 8'h84, 8'h0C};
  logic [15:0] f2_img [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

  logic [13:0] exp;

  task automatic send(input logic [15:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_basic();
    send(16'h1111); send(16'h2222); send(16'h3333); send(16'h4444);
  endtask

  task automatic test_reset();
    res = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_async: got %h expected %h", obs, IDLE);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", obs, IDLE);
    end
    res = 1'b0;
  endtask

  task automatic test_basic();
    send(16'h1111); send(16'h2222); send(16'h3333);
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL basic_prestream: got %h expected %h", obs, IDLE);
    end
    send(16'h4444);
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, basic_d[b % 2], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL basic_return: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_order();
    send(16'hABCD); send(16'h0000); send(16'h0000); send(16'h0000);
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, ord_d[b], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL order_beat%0d: got %h expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    send_basic();
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, basic_d[b % 2], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_beat%0d: got %h expected %h", b, obs, exp);
      end
      if (b == 2) begin
        bus.out_ready = 1'b0;
        for (int h = 0; h < 3; h++) begin
          @(posedge clk); #1;
          checks++;
          if (obs !== exp) begin
            errors++;
            $display("FAIL bp_hold%0d: got %h expected %h", h, obs, exp);
          end
        end
        bus.out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL bp_return: got %h expected %h", obs, IDLE);
    end
  endtask

  task automatic test_gaps();
    logic [15:0] imgs [4];
    imgs = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int k = 0; k < 4; k++) begin
      send(imgs[k]);
      if (k < 3) begin
        for (int g = 0; g < 2; g++) begin
          @(posedge clk); #1;
          checks++;
          if (obs !== IDLE) begin
            errors++;
            $display("FAIL gap_idle%0d_%0d: got %h expected %h",
                     k, g, obs, IDLE);
          end
        end
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, basic_d[b % 2], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL gap_beat%0d: got %h expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL gap_return: got %h expected %h", obs, IDLE);
    end
    test_order();
  endtask

  task automatic test_reset_mid();
    send_basic();
    repeat (4) begin
      @(posedge clk); #1;
    end
    exp = {4'h3, 8'h21, 1'b0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rmid_beat5: got %h expected %h", obs, exp);
    end
    #1 res = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL rmid_async: got %h expected %h", obs, IDLE);
    end
    @(posedge clk); #1;
    res = 1'b0;
    send(16'hEEEE); send(16'hEEEE);
    res = 1'b1;
    #1;
    res = 1'b0;
    for (int k = 0; k < 4; k++) send(f2_img[k]);
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, f2_d[b], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL rmid_beat%0d: got %h expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] f1 [4];
    f1 = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bus.in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.in_data = f1[k];
      @(posedge clk); #1;
    end
    bus.in_data = f2_img[0];
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, basic_d[b % 2], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_f1_beat%0d: got %h expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL b2b_reload: got %h expected %h", obs, IDLE);
    end
    for (int k = 0; k < 4; k++) begin
      bus.in_data = f2_img[k];
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    for (int b = 0; b < 8; b++) begin
      exp = {(b % 2) ? 4'hC : 4'h3, f2_d[b], b == 7, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b_f2_beat%0d: got %h expected %h", b, obs, exp);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL b2b_return: got %h expected %h", obs, IDLE);
    end
  endtask

  initial begin
    res           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_order();
    test_backpressure();
    test_gaps();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
